// File: rtl/ntt_sched_pkg.sv
// Shared definitions for the NTT stage scheduler.
// Holds the FSM state encoding, the default read and butterfly latencies,
// the resulting write-back delays for CT and GS mode, and max_lat(), which
// sizes the write-back delay line.
package ntt_sched_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_ISSUE = 2'd1;
  localparam fsm_state_t ST_DRAIN = 2'd2;
  localparam fsm_state_t ST_DONE  = 2'd3;

  localparam int DEF_RD_LAT = 1;
  localparam int DEF_LAT_CT = 17;
  localparam int DEF_LAT_GS = 19;

  // Read-to-write-back distance seen by the scheduler in each mode.
  localparam int D_CT = DEF_RD_LAT + DEF_LAT_CT;
  localparam int D_GS = DEF_RD_LAT + DEF_LAT_GS;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Write-back delay line for the NTT scheduler.
// Carries a valid bit and the two operand addresses of every issued
// butterfly. The output is taken at depth TAP_CT or TAP_GS, so results are
// written back in the same cycle the butterfly produces them.
// Ports:
//   clk, rst         clock and synchronous active-high clear
//   sel_ct           1 selects the CT tap, 0 selects the GS tap
//   in_vld           read strobe of the current cycle
//   in_a, in_b       read addresses of the current cycle
//   out_vld          delayed strobe (write enable)
//   out_a, out_b     delayed addresses (write addresses)
module ntt_addr_delay
  import ntt_sched_pkg::*;
#(
  parameter int AW     = 12,
  parameter int TAP_CT = D_CT,
  parameter int TAP_GS = D_GS,
  parameter int DEPTH  = max_lat(TAP_CT, TAP_GS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel_ct,
  input  logic          in_vld,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic          out_vld,
  output logic [AW-1:0] out_a,
  output logic [AW-1:0] out_b
);

  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    a_q [DEPTH];
  logic [AW-1:0]    b_q [DEPTH];

  // Entry k holds what was presented k+1 cycles ago, so a tap of depth D
  // reproduces the read of exactly D cycles earlier. Clearing the valid
  // bits on reset cancels every write still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      vld    <= {vld[DEPTH-2:0], in_vld};
      a_q[0] <= in_a;
      b_q[0] <= in_b;
      for (int k = 1; k < DEPTH; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end
  end

  assign out_vld = sel_ct ? vld[TAP_CT-1] : vld[TAP_GS-1];
  assign out_a   = sel_ct ? a_q[TAP_CT-1] : a_q[TAP_GS-1];
  assign out_b   = sel_ct ? b_q[TAP_CT-1] : b_q[TAP_GS-1];

endmodule

// File: rtl/ntt_stage_scheduler.sv
// Address and timing controller for one in-place NTT (CT) or iNTT (GS).
// Issues one butterfly per cycle (operand addresses plus twiddle index),
// delays the operand addresses to the butterfly output for write-back, and
// drains the pipeline between stages.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start, use_ct          transform request and mode (1 = CT, 0 = GS)
//   busy, done             transform in progress / one-cycle completion
//   bfly_use_ct            latched mode for the butterfly
//   rd_en, rd_addr_a/b     coefficient read strobe and operand addresses
//   tw_addr                twiddle ROM index
//   wr_en, wr_addr_a/b     write-back strobe and destination addresses
module ntt_stage_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int LOG_N  = 12,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int LAT_CT = DEF_LAT_CT,
  parameter int LAT_GS = DEF_LAT_GS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_ct,
  output logic             busy,
  output logic             done,
  output logic             bfly_use_ct,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int DLY_CT  = RD_LAT + LAT_CT;
  localparam int DLY_GS  = RD_LAT + LAT_GS;
  localparam int DLY_MAX = max_lat(DLY_CT, DLY_GS);
  localparam int SW      = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int CW      = $clog2(DLY_MAX + 1);
  localparam int KW      = LOG_N - 1;

  fsm_state_t       state;
  logic [SW-1:0]    stage;
  logic [KW-1:0]    k;
  logic [CW-1:0]    drain;
  logic             mode;

  logic [SW-1:0]    sh;
  logic [LOG_N-1:0] kx;
  logic [LOG_N-1:0] low_mask;
  logic [LOG_N-1:0] addr_a;
  logic [LOG_N-1:0] addr_b;
  logic [LOG_N-1:0] addr_tw;
  logic             issuing;

  // k counts butterflies within a stage. With t = 1 << sh, the nested
  // (i, j) loop is i = k >> sh, j = k mod t, so 2*i*t + j is k with a zero
  // bit inserted at position sh, and the b operand sets that bit. The
  // twiddle index m + i uses m = N / (2t).
  always_comb begin
    sh       = mode ? (SW'(LOG_N - 1) - stage) : stage;
    kx       = {1'b0, k};
    low_mask = (LOG_N'(1) << sh) - LOG_N'(1);
    addr_a   = ((kx & ~low_mask) << 1) | (kx & low_mask);
    addr_b   = addr_a | (LOG_N'(1) << sh);
    addr_tw  = (LOG_N'(1) << (SW'(LOG_N - 1) - sh)) + (kx >> sh);
  end

  // Stage sequencing. The drain counter is loaded with the write-back
  // delay on the last issue, so the next stage's first read lands in the
  // cycle after the previous stage's last write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      stage <= '0;
      k     <= '0;
      drain <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ISSUE;
            mode  <= use_ct;
            stage <= '0;
            k     <= '0;
          end
        end
        ST_ISSUE: begin
          k <= k + KW'(1);
          if (&k) begin
            state <= ST_DRAIN;
            drain <= mode ? CW'(DLY_CT) : CW'(DLY_GS);
          end
        end
        ST_DRAIN: begin
          if (drain == CW'(1)) begin
            drain <= '0;
            if (stage == SW'(LOG_N - 1)) begin
              state <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
              stage <= stage + SW'(1);
            end
          end else begin
            drain <= drain - CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign issuing     = (state == ST_ISSUE);
  assign busy        = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done        = (state == ST_DONE);
  assign bfly_use_ct = mode;
  assign rd_en       = issuing;
  assign rd_addr_a   = issuing ? addr_a  : '0;
  assign rd_addr_b   = issuing ? addr_b  : '0;
  assign tw_addr     = issuing ? addr_tw : '0;

  ntt_addr_delay #(
    .AW     (LOG_N),
    .TAP_CT (DLY_CT),
    .TAP_GS (DLY_GS),
    .DEPTH  (DLY_MAX)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .sel_ct  (mode),
    .in_vld  (rd_en),
    .in_a    (rd_addr_a),
    .in_b    (rd_addr_b),
    .out_vld (wr_en),
    .out_a   (wr_addr_a),
    .out_b   (wr_addr_b)
  );

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Testbench for ntt_stage_scheduler with LOG_N = 3.
// A negedge monitor logs every read, write, done and busy cycle. Each test
// task compares those logs against constants or against a loop-based model
// of the transform built from the addressing and timing rules.
module tb_ntt_stage_scheduler;

  localparam int LOG_N  = 3;
  localparam int N      = 8;
  localparam int RD_LAT = 1;
  localparam int LAT_CT = 17;
  localparam int LAT_GS = 19;

  typedef struct packed {
    int c;
    int a;
    int b;
    int tw;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             use_ct;
  logic             busy;
  logic             done;
  logic             bfly_use_ct;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-1:0] tw_addr;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t exp_rd[$];
  ev_t exp_wr[$];
  int  done_q[$];
  int  busy_q[$];
  int  exp_done;

  ntt_stage_scheduler #(
    .LOG_N  (LOG_N),
    .RD_LAT (RD_LAT),
    .LAT_CT (LAT_CT),
    .LAT_GS (LAT_GS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .use_ct      (use_ct),
    .busy        (busy),
    .done        (done),
    .bfly_use_ct (bfly_use_ct),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .tw_addr     (tw_addr),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_addr_b   (wr_addr_b)
  );

  always #5 clk = ~clk;

  // After posedge k, cyc == k and the outputs on display belong to cycle k.
  always @(posedge clk) cyc <= cyc + 1;

  // Log DUT activity mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rd_en === 1'b1)
      rd_q.push_back('{cyc, int'(rd_addr_a), int'(rd_addr_b), int'(tw_addr)});
    if (wr_en === 1'b1)
      wr_q.push_back('{cyc, int'(wr_addr_a), int'(wr_addr_b), 0});
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b1) busy_q.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    busy_q.delete();
  endtask

  task automatic pulse_start(input bit ct, output int sc);
    start  = 1'b1;
    use_ct = ct;
    sc     = cyc;
    step(1);
    start  = 1'b0;
    use_ct = 1'($urandom_range(0, 1));
  endtask

  // Reference transform: nested stage / group / butterfly loops, with each
  // stage taking N/2 issue cycles followed by D drain cycles.
  task automatic build_model(input bit ct, input int sc);
    int d, c, t, m, a;
    d = RD_LAT + (ct ? LAT_CT : LAT_GS);
    c = sc + 1;
    exp_rd.delete();
    exp_wr.delete();
    for (int s = 0; s < LOG_N; s++) begin
      t = ct ? (N >> (s + 1)) : (1 << s);
      m = ct ? (1 << s) : (N >> (s + 1));
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < t; j++) begin
          a = 2 * i * t + j;
          exp_rd.push_back('{c, a, a + t, m + i});
          exp_wr.push_back('{c + d, a, a + t, 0});
          c++;
        end
      end
      c += d;
    end
    exp_done = sc + LOG_N * (N / 2 + d) + 1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b1;
    use_ct = 1'b1;
    step(2);
    tests++;
    if ({busy, done, bfly_use_ct, rd_en, rd_addr_a, rd_addr_b, tw_addr,
         wr_en, wr_addr_a, wr_addr_b} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_values: got busy=%b done=%b mode=%b rd_en=%b wr_en=%b, required all 0",
               busy, done, bfly_use_ct, rd_en, wr_en);
    end
    rst   = 1'b0;
    start = 1'b0;
    step(3);
    tests++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_with_rst: got busy=%b rd_en=%b, required 0 0", busy, rd_en);
    end
  endtask

  task automatic test_ct_vectors();
    int sc;
    int ta[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int tb[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int ttw[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
    int tc[12]  = '{1, 2, 3, 4, 23, 24, 25, 26, 45, 46, 47, 48};
    ev_t want;
    clear_logs();
    pulse_start(1'b1, sc);
    step(72);
    tests++;
    if (rd_q.size() != 12) begin
      fails++;
      $display("[TB] FAIL ct_rd_count: got %0d, required 12", rd_q.size());
    end
    for (int x = 0; x < 12 && x < rd_q.size(); x++) begin
      want = '{sc + tc[x], ta[x], tb[x], ttw[x]};
      tests++;
      if (rd_q[x] !== want) begin
        fails++;
        $display("[TB] FAIL ct_vec[%0d]: got c=%0d (%0d,%0d,%0d), required c=%0d (%0d,%0d,%0d)",
                 x, rd_q[x].c - sc, rd_q[x].a, rd_q[x].b, rd_q[x].tw, tc[x], ta[x], tb[x], ttw[x]);
      end
    end
    tests++;
    if (wr_q.size() != 12 || wr_q[0].c != sc + 19 || wr_q[3].c != sc + 22 || wr_q[11].c != sc + 66) begin
      fails++;
      $display("[TB] FAIL ct_wr_timing: got count %0d, required 12 writes at 19..22 and last at 66", wr_q.size());
    end
    tests++;
    if (done_q.size() != 1 || done_q[0] != sc + 67) begin
      fails++;
      $display("[TB] FAIL ct_done: got %0d pulses (first rel %0d), required one at 67",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - sc : -1);
    end
    tests++;
    if (busy_q.size() != 66 || busy_q[0] != sc + 1 || busy_q[65] != sc + 66) begin
      fails++;
      $display("[TB] FAIL ct_busy: got %0d busy cycles, required 66 from 1 to 66", busy_q.size());
    end
  endtask

  task automatic test_gs_vectors();
    int sc;
    int ta[8]  = '{0, 2, 4, 6, 0, 1, 2, 3};
    int tb[8]  = '{1, 3, 5, 7, 4, 5, 6, 7};
    int ttw[8] = '{4, 5, 6, 7, 1, 1, 1, 1};
    int tc[8]  = '{1, 2, 3, 4, 49, 50, 51, 52};
    int idx[8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    ev_t want;
    clear_logs();
    pulse_start(1'b0, sc);
    step(78);
    tests++;
    if (rd_q.size() != 12) begin
      fails++;
      $display("[TB] FAIL gs_rd_count: got %0d, required 12", rd_q.size());
    end
    for (int x = 0; x < 8 && rd_q.size() == 12; x++) begin
      want = '{sc + tc[x], ta[x], tb[x], ttw[x]};
      tests++;
      if (rd_q[idx[x]] !== want) begin
        fails++;
        $display("[TB] FAIL gs_vec[%0d]: got c=%0d (%0d,%0d,%0d), required c=%0d (%0d,%0d,%0d)",
                 idx[x], rd_q[idx[x]].c - sc, rd_q[idx[x]].a, rd_q[idx[x]].b, rd_q[idx[x]].tw,
                 tc[x], ta[x], tb[x], ttw[x]);
      end
    end
    tests++;
    if (wr_q.size() == 0 || wr_q[0].c != sc + 21) begin
      fails++;
      $display("[TB] FAIL gs_first_wr: got rel %0d, required 21", (wr_q.size() > 0) ? wr_q[0].c - sc : -1);
    end
    tests++;
    if (done_q.size() != 1 || done_q[0] != sc + 73) begin
      fails++;
      $display("[TB] FAIL gs_done: got %0d pulses (first rel %0d), required one at 73",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - sc : -1);
    end
  endtask

  // Full transform against the model; extra > 0 pulses a second start
  // (opposite mode) that many cycles after the accepted one.
  task automatic test_transform(input bit ct, input int extra, input string tag);
    int sc;
    clear_logs();
    step($urandom_range(1, 4));
    pulse_start(ct, sc);
    build_model(ct, sc);
    if (extra > 0) begin
      step(extra - 1);
      start  = 1'b1;
      use_ct = !ct;
      step(1);
      start  = 1'b0;
    end
    while (done_q.size() == 0 && cyc < exp_done + 5) step(1);
    step(3);
    tests++;
    if (rd_q.size() != exp_rd.size() || wr_q.size() != exp_wr.size()) begin
      fails++;
      $display("[TB] FAIL %s counts: got rd=%0d wr=%0d, required rd=%0d wr=%0d",
               tag, rd_q.size(), wr_q.size(), exp_rd.size(), exp_wr.size());
    end
    for (int x = 0; x < exp_rd.size() && x < rd_q.size(); x++) begin
      tests++;
      if (rd_q[x] !== exp_rd[x]) begin
        fails++;
        $display("[TB] FAIL %s rd[%0d]: got c=%0d (%0d,%0d,%0d), required c=%0d (%0d,%0d,%0d)",
                 tag, x, rd_q[x].c - sc, rd_q[x].a, rd_q[x].b, rd_q[x].tw,
                 exp_rd[x].c - sc, exp_rd[x].a, exp_rd[x].b, exp_rd[x].tw);
      end
    end
    for (int x = 0; x < exp_wr.size() && x < wr_q.size(); x++) begin
      tests++;
      if (wr_q[x] !== exp_wr[x]) begin
        fails++;
        $display("[TB] FAIL %s wr[%0d]: got c=%0d (%0d,%0d), required c=%0d (%0d,%0d)",
                 tag, x, wr_q[x].c - sc, wr_q[x].a, wr_q[x].b,
                 exp_wr[x].c - sc, exp_wr[x].a, exp_wr[x].b);
      end
    end
    tests++;
    if (done_q.size() != 1 || done_q[0] != exp_done) begin
      fails++;
      $display("[TB] FAIL %s done: got %0d pulses (first rel %0d), required one at %0d",
               tag, done_q.size(), (done_q.size() > 0) ? done_q[0] - sc : -1, exp_done - sc);
    end
    tests++;
    if (busy_q.size() != exp_done - sc - 1 || busy_q[0] != sc + 1) begin
      fails++;
      $display("[TB] FAIL %s busy: got %0d cycles, required %0d from rel 1", tag, busy_q.size(), exp_done - sc - 1);
    end
  endtask

  task automatic test_random_modes();
    bit ct;
    for (int r = 0; r < 4; r++) begin
      ct = 1'($urandom_range(0, 1));
      test_transform(ct, 0, ct ? "rand_ct" : "rand_gs");
    end
  endtask

  task automatic test_start_ignored();
    test_transform(1'b1, 10, "start_busy_ct");
    test_transform(1'b0, $urandom_range(2, 70), "start_busy_gs");
  endtask

  // Start in the DONE cycle is ignored; start one cycle later is accepted.
  task automatic test_back_to_back();
    int sc, sc2, stray;
    clear_logs();
    pulse_start(1'b1, sc);
    step(66);
    start  = 1'b1;
    use_ct = 1'b1;
    step(1);
    start  = 1'b0;
    pulse_start(1'b0, sc2);
    step(5);
    stray = 0;
    foreach (busy_q[x]) if (busy_q[x] == sc + 68) stray++;
    tests++;
    if (stray != 0) begin
      fails++;
      $display("[TB] FAIL b2b_done_start: got busy at rel 68, required idle");
    end
    while (done_q.size() < 2 && cyc < sc2 + 80) step(1);
    tests++;
    if (done_q.size() != 2 || done_q[0] != sc + 67 || done_q[1] != sc2 + 73) begin
      fails++;
      $display("[TB] FAIL b2b_done: got %0d pulses, required at %0d and %0d", done_q.size(), sc + 67, sc2 + 73);
    end
    tests++;
    if (rd_q.size() != 24 || rd_q[12].c != sc2 + 1 || rd_q[12].tw != 4) begin
      fails++;
      $display("[TB] FAIL b2b_second_run: got %0d reads, required 24 with GS start at rel 1", rd_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    int sc, sc2, late;
    clear_logs();
    pulse_start(1'b1, sc);
    step(19);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    late = 0;
    foreach (rd_q[x]) if (rd_q[x].c >= sc + 21) late++;
    foreach (wr_q[x]) if (wr_q[x].c >= sc + 21) late++;
    foreach (busy_q[x]) if (busy_q[x] >= sc + 21) late++;
    tests++;
    if (late != 0 || done_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL abort: got %0d late events and %0d done, required 0 and 0", late, done_q.size());
    end
    tests++;
    if (wr_q.size() != 2) begin
      fails++;
      $display("[TB] FAIL abort_writes: got %0d writes before abort, required 2", wr_q.size());
    end
    clear_logs();
    pulse_start(1'b1, sc2);
    while (done_q.size() == 0 && cyc < sc + 100) step(1);
    tests++;
    if (done_q.size() != 1 || done_q[0] != sc + 92 || rd_q.size() != 12 || wr_q.size() != 12) begin
      fails++;
      $display("[TB] FAIL rerun: got done rel %0d rd=%0d wr=%0d, required done 92 rd=12 wr=12",
               (done_q.size() > 0) ? done_q[0] - sc : -1, rd_q.size(), wr_q.size());
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    use_ct = 1'b0;
    step(1);
    test_reset();
    test_ct_vectors();
    test_gs_vectors();
    test_transform(1'b1, 0, "model_ct");
    test_transform(1'b0, 0, "model_gs");
    test_random_modes();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
